// File: rtl/level_shifted_pwm_modulator.sv
// Level-shifted PWM modulator for two cascaded H-bridges: double-buffered reference,
// registered carrier compare and four dead-time protected gate legs with fault latch.
module level_shifted_pwm_modulator #(
  parameter int DATA_WIDTH = 16,
  parameter int DT_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] mod_in,
  input  logic                         mod_valid,
  input  logic signed [DATA_WIDTH-1:0] carrier1,
  input  logic signed [DATA_WIDTH-1:0] carrier2,
  input  logic                         sync_pulse,
  input  logic [DT_WIDTH-1:0]          deadtime_cycles,
  input  logic                         fault,
  input  logic                         fault_clear,
  output logic [3:0]                   pwm_hi,
  output logic [3:0]                   pwm_lo,
  output logic signed [2:0]            out_level,
  output logic                         fault_latched,
  output logic                         running
);

  localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {OFF, DEAD_TO_HI, HI_ON, DEAD_TO_LO, LO_ON} leg_state_t;

  logic signed [DATA_WIDTH-1:0] shadow, active, mod_inv;
  logic [3:0]                   cmp_d, cmp_q;
  logic signed [2:0]            level_d;
  leg_state_t                   state [4];
  leg_state_t                   state_nxt [4];
  logic [DT_WIDTH-1:0]          cnt [4];
  logic [DT_WIDTH-1:0]          cnt_nxt [4];
  logic [3:0]                   hi_d, lo_d;
  logic                         kill;

  // A simultaneous write and sync bypasses the shadow so the new value takes effect now.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (mod_valid) shadow <= mod_in;
      if (mod_valid && sync_pulse) active <= mod_in;
      else if (sync_pulse) active <= shadow;
    end
  end

  assign mod_inv = (active == S_MIN) ? S_MAX : -active;

  always_comb begin
    cmp_d   = {mod_inv > carrier2, active > carrier2, mod_inv > carrier1, active > carrier1};
    level_d = ($signed({2'b00, cmp_d[0]}) - $signed({2'b00, cmp_d[1]}))
            + ($signed({2'b00, cmp_d[2]}) - $signed({2'b00, cmp_d[3]}));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q         <= '0;
      out_level     <= '0;
      fault_latched <= 1'b0;
    end else begin
      cmp_q     <= cmp_d;
      out_level <= level_d;
      if (fault) fault_latched <= 1'b1;
      else if (fault_clear) fault_latched <= 1'b0;
    end
  end

  assign kill = fault | fault_latched | ~enable;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        state[i] <= OFF;
        cnt[i]   <= '0;
      end else begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  // With zero dead time the dead state is skipped so the switchover happens on one edge.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      if (kill) begin
        state_nxt[i] = OFF;
      end else begin
        case (state[i])
          OFF: if (sync_pulse) begin
            state_nxt[i] = cmp_q[i] ? DEAD_TO_HI : DEAD_TO_LO;
            cnt_nxt[i]   = deadtime_cycles;
          end
          LO_ON: if (cmp_q[i]) begin
            state_nxt[i] = DEAD_TO_HI;
            cnt_nxt[i]   = deadtime_cycles;
          end
          HI_ON: if (!cmp_q[i]) begin
            state_nxt[i] = DEAD_TO_LO;
            cnt_nxt[i]   = deadtime_cycles;
          end
          DEAD_TO_HI: begin
            if (!cmp_q[i]) state_nxt[i] = LO_ON;
            else if (cnt[i] <= DT_WIDTH'(1)) state_nxt[i] = HI_ON;
            else cnt_nxt[i] = cnt[i] - DT_WIDTH'(1);
          end
          DEAD_TO_LO: begin
            if (cmp_q[i]) state_nxt[i] = HI_ON;
            else if (cnt[i] <= DT_WIDTH'(1)) state_nxt[i] = LO_ON;
            else cnt_nxt[i] = cnt[i] - DT_WIDTH'(1);
          end
          default: state_nxt[i] = OFF;
        endcase
        if (state_nxt[i] != state[i] && deadtime_cycles == '0) begin
          if (state_nxt[i] == DEAD_TO_HI) state_nxt[i] = HI_ON;
          else if (state_nxt[i] == DEAD_TO_LO) state_nxt[i] = LO_ON;
        end
      end
    end
  end

  // Gates are decoded from one state per leg, and forced low on the edge a shutdown is seen.
  always_comb begin
    running = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hi_d[i] = ~kill & (state[i] == HI_ON);
      lo_d[i] = ~kill & (state[i] == LO_ON);
      if (state[i] != OFF) running = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_hi <= '0;
      pwm_lo <= '0;
    end else begin
      pwm_hi <= hi_d;
      pwm_lo <= lo_d;
    end
  end

endmodule

// File: tb/tb_level_shifted_pwm_modulator.sv
// Randomized bench for level_shifted_pwm_modulator against a behavioural leg/buffer model,
// with a few directed reference-buffering and saturation checks.
module tb_level_shifted_pwm_modulator;

  logic               clk = 1'b0;
  logic               rst, enable, mod_valid, sync_pulse, fault, fault_clear;
  logic signed [15:0] mod_in, carrier1, carrier2;
  logic [7:0]         deadtime_cycles;
  logic [3:0]         pwm_hi, pwm_lo;
  logic signed [2:0]  out_level;
  logic               fault_latched, running;

  int n_cmp = 0;
  int n_err = 0;

  // Model: each leg is either idle, or aiming at one gate with some cycles left before it conducts.
  int m_shadow, m_active, m_fl, m_level;
  bit [3:0] m_ref;
  bit m_alive [4];
  bit m_target [4];
  int m_remain [4];
  int e_hi, e_lo;

  level_shifted_pwm_modulator dut (
    .clk(clk), .rst(rst), .enable(enable), .mod_in(mod_in), .mod_valid(mod_valid),
    .carrier1(carrier1), .carrier2(carrier2), .sync_pulse(sync_pulse),
    .deadtime_cycles(deadtime_cycles), .fault(fault), .fault_clear(fault_clear),
    .pwm_hi(pwm_hi), .pwm_lo(pwm_lo), .out_level(out_level),
    .fault_latched(fault_latched), .running(running)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelEdge();
    bit kill;
    int a, inv, c1, c2, d;
    kill = rst || fault || (m_fl != 0) || !enable;
    e_hi = 0;
    e_lo = 0;
    for (int i = 0; i < 4; i++)
      if (!kill && m_alive[i] && m_remain[i] == 0) begin
        if (m_target[i]) e_hi |= (1 << i);
        else e_lo |= (1 << i);
      end
    if (rst) begin
      m_shadow = 0; m_active = 0; m_fl = 0; m_level = 0; m_ref = '0;
      for (int i = 0; i < 4; i++) begin
        m_alive[i] = 0; m_target[i] = 0; m_remain[i] = 0;
      end
      return;
    end
    d = deadtime_cycles;
    for (int i = 0; i < 4; i++) begin
      if (kill) m_alive[i] = 0;
      else if (!m_alive[i]) begin
        if (sync_pulse) begin
          m_alive[i] = 1; m_target[i] = m_ref[i]; m_remain[i] = d;
        end
      end else if (m_ref[i] != m_target[i]) begin
        m_remain[i] = (m_remain[i] > 0) ? 0 : d;
        m_target[i] = m_ref[i];
      end else if (m_remain[i] > 0) begin
        m_remain[i]--;
      end
    end
    a   = m_active;
    inv = (a == -32768) ? 32767 : -a;
    c1  = carrier1;
    c2  = carrier2;
    m_ref   = {inv > c2, a > c2, inv > c1, a > c1};
    m_level = int'(m_ref[0]) - int'(m_ref[1]) + int'(m_ref[2]) - int'(m_ref[3]);
    if (mod_valid && sync_pulse) begin
      m_shadow = mod_in; m_active = mod_in;
    end else if (mod_valid) m_shadow = mod_in;
    else if (sync_pulse) m_active = m_shadow;
    if (fault) m_fl = 1;
    else if (fault_clear) m_fl = 0;
  endtask

  task automatic applyStimulus();
    int any;
    @(posedge clk);
    modelEdge();
    #1;
    any = 0;
    for (int i = 0; i < 4; i++) if (m_alive[i]) any = 1;
    checkOutput("pwm_hi", pwm_hi, e_hi);
    checkOutput("pwm_lo", pwm_lo, e_lo);
    checkOutput("overlap", pwm_hi & pwm_lo, 0);
    checkOutput("out_level", out_level, m_level);
    checkOutput("fault_latched", fault_latched, m_fl);
    checkOutput("running", running, any);
  endtask

  initial begin
    int ph, dir;
    rst = 1'b1; enable = 1'b0; mod_valid = 1'b0; sync_pulse = 1'b0; fault = 1'b0;
    fault_clear = 1'b0; mod_in = '0; carrier1 = '0; carrier2 = '0; deadtime_cycles = 8'd0;
    repeat (3) applyStimulus();
    checkOutput("reset_hi", pwm_hi, 0);
    checkOutput("reset_lo", pwm_lo, 0);
    checkOutput("reset_level", out_level, 0);
    checkOutput("reset_running", running, 0);
    rst = 1'b0;
    enable = 1'b1;
    deadtime_cycles = 8'd3;

    // Negation of the most negative reference saturates, driving both inverted compares high.
    mod_in = -16'sd32768; mod_valid = 1'b1; sync_pulse = 1'b1;
    carrier1 = -16'sd1; carrier2 = 16'sd32766;
    applyStimulus();
    mod_valid = 1'b0; sync_pulse = 1'b0;
    applyStimulus();
    checkOutput("sat_level", out_level, -2);

    carrier1 = -16'sd10000; carrier2 = 16'sd100;
    mod_in = 16'sd20000; mod_valid = 1'b1;
    applyStimulus();
    mod_valid = 1'b0;
    applyStimulus();
    checkOutput("shadow_hold", out_level, -2);
    sync_pulse = 1'b1;
    applyStimulus();
    sync_pulse = 1'b0;
    applyStimulus();
    checkOutput("sync_xfer", out_level, 2);
    mod_in = -16'sd5000; mod_valid = 1'b1; sync_pulse = 1'b1;
    applyStimulus();
    mod_valid = 1'b0; sync_pulse = 1'b0;
    applyStimulus();
    checkOutput("bypass", out_level, -1);

    ph = 0;
    dir = 1;
    for (int n = 0; n < 4000; n++) begin
      ph += dir;
      if (ph == 63) dir = -1;
      if (ph == 0) dir = 1;
      carrier2 = 16'(ph * 512 + $urandom_range(0, 511));
      carrier1 = 16'(int'(carrier2) - 32768);
      sync_pulse = (ph == 0 || ph == 63 || $urandom_range(0, 31) == 0);
      mod_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 9))
        0:       mod_in = -16'sd32768;
        1:       mod_in = 16'sd32767;
        default: mod_in = 16'($urandom);
      endcase
      deadtime_cycles = 8'($urandom_range(0, 12));
      enable = ($urandom_range(0, 99) != 0);
      fault = ($urandom_range(0, 149) == 0);
      fault_clear = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 499) == 0);
      applyStimulus();
    end

    rst = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("midrun_rst_hi", pwm_hi, 0);
    checkOutput("midrun_rst_lo", pwm_lo, 0);
    checkOutput("midrun_rst_fault", fault_latched, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
